// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - bus-mapped UART transmitter; UART_TX_FIFO_EN selects FIFO_DEPTH queue vs single holding register

module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_tvalid,
    input  logic [7:0] in_tdata,
    output logic       in_tready,
    output logic       out_tvalid,
    output logic [7:0] out_tdata,
    input  logic       out_tready,
    output logic       full
);
    logic pop_ok;
    logic push_ok;

    // A pop in the same cycle frees a slot, so a push into a full queue still lands.
    assign pop_ok    = out_tready & out_tvalid;
    assign in_tready = ~full | pop_ok;
    assign push_ok   = in_tvalid & in_tready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0);
        end
    end

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full       = (count == (AW+1)'(DEPTH));
    assign out_tvalid = (count != '0);
    assign out_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= in_tdata;
    end
`else
    logic [7:0] hold;
    logic       hold_valid;

    assign full       = hold_valid;
    assign out_tvalid = hold_valid;
    assign out_tdata  = hold;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_valid <= 1'b0;
        end else if (push_ok) begin
            hold_valid <= 1'b1;
        end else if (pop_ok) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) hold <= in_tdata;
    end
`endif
endmodule

module uart_tx_engine #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BAUD  = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [7:0]  wb_addr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack,
    output logic        uart_tx,
    output logic        irq
);
    localparam logic [15:0] BAUD_RESET = 16'(CLK_FREQ / UART_BAUD);
    localparam logic [15:0] BAUD_MIN   = 16'd16;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state;
    state_t      state_next;
    logic        tx_en;
    logic        irq_en;
    logic        overflow;
    logic [15:0] baud_div;
    logic [15:0] bit_div;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bus_cyc;
    logic        fifo_push;
    logic        fifo_flush;
    logic        fifo_in_tready;
    logic        fifo_out_tvalid;
    logic [7:0]  fifo_out_tdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        load_frame;
    logic        bit_end;
    logic        busy;
    logic        unused_ok;

    assign bus_cyc    = wb_stb & ~wb_ack;
    assign fifo_push  = bus_cyc & wb_we & (wb_addr == 8'h00);
    assign fifo_flush = bus_cyc & wb_we & (wb_addr == 8'h08) & wb_dat_i[1];
    assign fifo_empty = ~fifo_out_tvalid;
    assign busy       = (state != S_IDLE);
    assign bit_end    = (bit_cnt == bit_div - 16'd1);
    assign unused_ok  = &{1'b0, wb_dat_i[31:16]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (fifo_flush),
        .in_tvalid  (fifo_push),
        .in_tdata   (wb_dat_i[7:0]),
        .in_tready  (fifo_in_tready),
        .out_tvalid (fifo_out_tvalid),
        .out_tdata  (fifo_out_tdata),
        .out_tready (load_frame),
        .full       (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ack   <= 1'b0;
            wb_dat_o <= '0;
            tx_en    <= 1'b1;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            baud_div <= BAUD_RESET;
        end else begin
            wb_ack   <= bus_cyc;
            wb_dat_o <= '0;
            if (fifo_push && !fifo_in_tready) overflow <= 1'b1;
            if (bus_cyc && wb_we) begin
                case (wb_addr)
                    8'h08: begin
                        tx_en  <= wb_dat_i[0];
                        irq_en <= wb_dat_i[2];
                    end
                    8'h0C: baud_div <= (wb_dat_i[15:0] < BAUD_MIN) ? BAUD_MIN : wb_dat_i[15:0];
                    default: ;
                endcase
            end else if (bus_cyc) begin
                case (wb_addr)
                    8'h04: begin
                        wb_dat_o <= {28'd0, overflow, fifo_empty, fifo_full, busy};
                        overflow <= 1'b0;
                    end
                    8'h08:   wb_dat_o <= {29'd0, irq_en, 1'b0, tx_en};
                    8'h0C:   wb_dat_o <= {16'd0, baud_div};
                    default: wb_dat_o <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_frame = 1'b0;
        uart_tx    = 1'b1;
        case (state)
            S_IDLE: begin
                if (tx_en && !fifo_empty) begin
                    state_next = S_START;
                    load_frame = 1'b1;
                end
            end
            S_START: begin
                uart_tx = 1'b0;
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                uart_tx = shreg[0];
                if (bit_end && bit_idx == 3'd7) state_next = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (tx_en && !fifo_empty) begin
                        state_next = S_START;
                        load_frame = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // bit_div is re-latched at every bit boundary so a BAUD_DIV write never stretches a bit already running.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            bit_div <= BAUD_RESET;
            bit_idx <= '0;
            shreg   <= '0;
            irq     <= 1'b0;
        end else begin
            irq <= irq_en & fifo_empty & ~busy;
            if (load_frame) begin
                shreg   <= fifo_out_tdata;
                bit_cnt <= '0;
                bit_div <= baud_div;
                bit_idx <= '0;
            end else if (busy) begin
                if (bit_end) begin
                    bit_cnt <= '0;
                    bit_div <= baud_div;
                    if (state == S_DATA) begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench for uart_tx_engine with serial receiver model
`timescale 1ns/1ps

module tb_uart_tx_engine;
`ifdef UART_TX_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_stb = 1'b0;
    logic        wb_we = 1'b0;
    logic [7:0]  wb_addr = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        uart_tx;
    logic        irq;

    uart_tx_engine dut (
        .clk      (clk),
        .rst      (rst),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack   (wb_ack),
        .uart_tx  (uart_tx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } rd_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    rd_t         rd_q[$];
    logic [7:0]  exp_q[$];
    int          start_q[$];
    bit          rx_en = 1'b1;
    int          tb_div = 434;
    int          occ = 0;
    bit          tx_on = 1'b1;
    bit          m_ovf = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] tmp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus response monitor
    always @(negedge clk) begin
        rd_t r;
        if (wb_ack === 1'b1) begin
            check("ack_one_cycle", prev_ack, 1'b0);
            if (rd_q.size() == 0) begin
                check("ack_unexpected", 1, 0);
            end else begin
                r = rd_q.pop_front();
                if (r.chk) check(r.name, wb_dat_o, r.exp);
            end
        end
        prev_ack <= wb_ack;
    end

    // Serial receiver: mid-bit sampling at the currently configured divisor
    initial begin
        logic [7:0] b;
        int d;
        forever begin
            @(negedge clk);
            if (rx_en && uart_tx === 1'b0) begin
                start_q.push_back(cyc);
                d = tb_div;
                repeat (d / 2) @(negedge clk);
                check("rx_start_bit", uart_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (d) @(negedge clk);
                check("rx_stop_bit", uart_tx, 1);
                if (exp_q.size() == 0) check("rx_unexpected_frame", 1, 0);
                else                   check("rx_byte", b, exp_q.pop_front());
            end
        end
    end

    initial begin
        #950_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic bus(input logic [7:0] a, input logic we, input logic [31:0] d, input bit chk,
                       input logic [31:0] exp, input string name, output logic [31:0] rd);
        rd_t e;
        e.chk = chk; e.exp = exp; e.name = name;
        @(negedge clk);
        wb_stb = 1'b1; wb_we = we; wb_addr = a; wb_dat_i = d;
        rd_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack === 1'b1) break;
        end
        if (wb_ack !== 1'b1) check({name, "_ack_timeout"}, wb_ack, 1);
        rd = wb_dat_o;
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        bus(a, 1'b1, d, 1'b0, '0, "wr", r);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string name);
        logic [31:0] r;
        bus(a, 1'b0, '0, 1'b1, exp, name, r);
    endtask

    function automatic logic [31:0] status_idle();
        return {28'd0, m_ovf, occ == 0, occ == CAP, 1'b0};
    endfunction

    task automatic rd_status(input string name);
        rd_chk(8'h04, status_idle(), name);
        m_ovf = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        wr(8'h00, {24'd0, b});
        if (!tx_on && occ >= CAP) begin
            m_ovf = 1'b1;
        end else begin
            exp_q.push_back(b);
            if (!tx_on) occ++;
        end
    endtask

    task automatic set_ctrl(input logic [31:0] d);
        wr(8'h08, d);
        if (d[1]) begin
            occ = 0;
            exp_q.delete();
        end
        tx_on = d[0];
        if (tx_on) occ = 0;
    endtask

    task automatic set_baud(input int d);
        wr(8'h0C, d);
        tb_div = (d < 16) ? 16 : d;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (tb_div + 4) @(negedge clk);
    endtask

    task automatic wait_fall(input string name);
        int i;
        for (i = 0; i < 40 && uart_tx !== 1'b0; i++) @(negedge clk);
        if (uart_tx !== 1'b0) check({name, "_no_start"}, uart_tx, 0);
    endtask

    initial begin
        logic [7:0] msg[5];
        int bad[10];
        int irq_bad;
        int n;
        msg = '{8'h54, 8'h45, 8'h53, 8'h54, 8'h0A};

        repeat (3) @(negedge clk);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_wb_ack", wb_ack, 0);
        check("reset_wb_dat_o", wb_dat_o, 0);
        check("reset_irq", irq, 0);
        rst = 1'b0;

        rd_chk(8'h04, 32'h4, "reset_status");
        rd_chk(8'h08, 32'h1, "reset_ctrl");
        rd_chk(8'h0C, 32'd434, "reset_baud");
        rd_chk(8'h00, 32'h0, "data_reads_zero");
        wr(8'h10, 32'hFFFF_FFFF);
        rd_chk(8'h10, 32'h0, "unmapped_reads_zero");
        rd_chk(8'h0C, 32'd434, "unmapped_write_ignored");

        set_baud(5);
        rd_chk(8'h0C, 32'd16, "baud_clamp_16");
        set_baud(32'h0001_2345);
        rd_chk(8'h0C, 32'h2345, "baud_16bit_field");

        // 0x55 at 16 cycles per bit, checked cycle by cycle
        set_baud(16);
        send_byte(8'h55);
        wait_fall("b55");
        for (int i = 0; i < 10; i++) bad[i] = 0;
        for (int k = 0; k < 160; k++) begin
            int bi;
            logic e;
            bi = k / 16;
            e = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : ((8'h55 >> (bi - 1)) & 1);
            if (uart_tx !== e) bad[bi]++;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) check($sformatf("b55_bit%0d_errcycles", i), bad[i], 0);
        check("b55_idle_after", uart_tx, 1);
        wait_drain();
        rd_status("b55_status_after");

        // "TEST\n" at the reset divisor, frames must abut
        set_baud(434);
        start_q.delete();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] st;
            st = 32'h2;
            for (int p = 0; p < 5000 && st[1]; p++) bus(8'h04, 1'b0, '0, 1'b0, '0, "poll", st);
            if (st[1]) check("test_poll_full", st[1], 0);
            send_byte(msg[i]);
        end
        wait_drain();
        check("test_frame_count", start_q.size(), 5);
        for (int i = 1; i < start_q.size() && i < 5; i++)
            check($sformatf("test_gap%0d", i), start_q[i] - start_q[i-1], 10 * 434);

        // Overflow with transmitter disabled, then flush
        set_baud(16);
        set_ctrl(32'h0);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom));
        rd_status("ovf_status_first");
        rd_status("ovf_status_second");
        set_ctrl(32'h2);
        rd_status("flush_status");
        set_ctrl(32'h1);
        repeat (40) @(negedge clk);
        rd_status("flush_no_frames");

        // Queue while disabled, then release
        set_ctrl(32'h0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        rd_status("held_status");
        set_ctrl(32'h1);
        wait_drain();
        rd_status("held_drained_status");

        // Random bursts at random divisors
        for (int it = 0; it < 6; it++) begin
            set_baud($urandom_range(48, 16));
            n = $urandom_range(CAP, 1);
            for (int j = 0; j < n; j++) send_byte(8'($urandom));
            wait_drain();
            rd_status($sformatf("rand%0d_status", it));
        end

        // TX-empty interrupt
        set_baud(16);
        set_ctrl(32'h5);
        send_byte(8'hA5);
        wait_fall("irq");
        irq_bad = 0;
        for (int k = 0; k < 160; k++) begin
            if (irq !== 1'b0) irq_bad++;
            @(negedge clk);
        end
        check("irq_low_during_frame", irq_bad, 0);
        repeat (2) @(negedge clk);
        check("irq_high_after_stop", irq, 1);
        wait_drain();
        set_ctrl(32'h1);

        // Reset during data bit 3
        set_baud(20);
        rx_en = 1'b0;
        wr(8'h00, 32'h0);
        wait_fall("rst");
        repeat (20 + 3 * 20 + 5) @(negedge clk);
        check("rst_mid_frame_low", uart_tx, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_uart_tx_high", uart_tx, 1);
        rst = 1'b0;
        tb_div = 434; tx_on = 1'b1; occ = 0; m_ovf = 1'b0;
        rd_chk(8'h04, 32'h4, "rst_status");
        rd_chk(8'h0C, 32'd434, "rst_baud");
        repeat (30) @(negedge clk);
        check("rst_line_stays_idle", uart_tx, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD, default 115200, reset baud rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries (power of 2).
REQ-004 SHALL have port clk  input  1  system clock; the sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port wb_stb  input  1  bus strobe.
REQ-007 SHALL have port wb_we  input  1  write enable.
REQ-008 SHALL have port wb_addr  input  8  byte offset: 0x00 DATA, 0x04 STATUS, 0x08 CTRL, 0x0C BAUD_DIV.
REQ-009 SHALL have port wb_dat_i  input  32  write data.
REQ-010 SHALL have port wb_dat_o  output  32  read data.
REQ-011 SHALL have port wb_ack  output  1  transfer acknowledge.
REQ-012 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-013 SHALL have port irq  output  1  TX-empty interrupt request.

Function
REQ-014 SHALL assert wb_ack for exactly one cycle, in the cycle after wb_stb is sampled high with wb_ack low; there SHALL be no back-to-back ack.
REQ-015 SHALL push wb_dat_i[7:0] into the FIFO on an acked write to DATA when not full; when full, the byte SHALL be dropped and sticky STATUS[3] overflow SHALL be set.
REQ-016 SHALL define STATUS bits: [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow. A STATUS read SHALL clear overflow in the ack cycle.
REQ-017 SHALL define CTRL bits: [0] tx_en (reset 1), [1] flush (self-clearing, empties the FIFO, no effect on the frame in flight), [2] irq_en (reset 0).
REQ-018 SHALL reset BAUD_DIV to CLK_FREQ/UART_BAUD (434 at defaults); a write of a value below 16 SHALL store 16; the field SHALL be 16 bits, with upper bits reading 0.
REQ-019 SHALL implement FSM IDLE->START->DATA->STOP->IDLE; IDLE->START when tx_en=1 and FIFO non-empty, popping the byte in the same cycle.
REQ-020 SHALL drive uart_tx to 0 in START, data bits LSB first in DATA, and 1 in STOP/IDLE; each bit SHALL last exactly BAUD_DIV cycles.
REQ-021 SHALL allow STOP->START directly, with no idle bit, if FIFO is non-empty and tx_en=1 at the end of STOP.
REQ-022 SHALL apply a BAUD_DIV change to a frame in flight only from the next bit boundary.
REQ-023 SHALL give priority to simultaneous push and pop on a full FIFO: the pop happens first and the push is accepted with no overflow.
REQ-024 SHALL finish the current frame when tx_en is cleared mid-frame, then hold in IDLE.
REQ-025 SHALL drive irq = irq_en & empty & ~busy, registered.
REQ-026 SHALL return 0 on reads of DATA and of unmapped offsets; writes to them SHALL be ignored, and both SHALL still be acked.

Reset
REQ-027 SHALL apply the following values on rst: uart_tx=1, wb_ack=0, wb_dat_o=0, irq=0, FSM=IDLE, FIFO empty, overflow=0, CTRL=0x1, BAUD_DIV per REQ-018.
REQ-028 SHALL abort a frame in flight when rst asserts mid-frame, with uart_tx high on the next cycle.

Configuration
REQ-029 SHALL, with UART_TX_FIFO_EN defined, build the FIFO_DEPTH-entry FIFO as above.
REQ-030 SHALL, without UART_TX_FIFO_EN, replace the FIFO with a single holding register: full = holding valid, empty = ~full; all other behaviour SHALL be unchanged.

Verification
REQ-031 SHALL cover: write BAUD_DIV=16, DATA=0x55 -> uart_tx low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high; STATUS=0x4 after the frame.
REQ-032 SHALL cover: write "TEST\n" (5 bytes) at default baud -> the bench receiver decodes 0x54,0x45,0x53,0x54,0x0A with no framing error, and adjacent frames have no idle gap.
REQ-033 SHALL cover: with tx_en=0, write 9 bytes (FIFO on) -> STATUS=0x0A (full+overflow); a second STATUS read returns 0x02.
REQ-034 SHALL cover: write BAUD_DIV=5 -> read returns 16.
REQ-035 SHALL cover: irq_en=1, send 1 byte -> irq=0 during the frame and irq=1 within 2 cycles after the stop bit ends.
REQ-036 SHALL cover: assert rst during DATA bit 3 -> uart_tx=1 next cycle, STATUS=0x4, and BAUD_DIV reads 434.
